// File: rtl/freq_tracker.sv
// Peak-amplitude hill-climbing frequency tracker.
// Steps the drive frequency toward the largest rectified ADC response.
module freq_tracker #(
  parameter int ADC_W      = 12,
  parameter int FREQ_W     = 20,
  parameter int SETTLE_CYC = 30000,
  parameter int MEAS_CYC   = 5000,
  parameter int HYST       = 8,
  parameter int OPT_REV    = 4,
  parameter int SAT_LEVEL  = 1739
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADC_W-1:0]  adc_in,
  input  logic              adc_valid,
  input  logic [FREQ_W-1:0] freq,
  input  logic              step_ack,
  output logic              step_req,
  output logic              step_up,
  output logic              busy,
  output logic              freq_opt,
  output logic              sat_flag,
  output logic [FREQ_W-1:0] best_freq,
  output logic [ADC_W-2:0]  best_amp
);

  localparam int AW = ADC_W - 1;
  localparam int CMAX =
    (SETTLE_CYC > MEAS_CYC) ? SETTLE_CYC : MEAS_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = $clog2(OPT_REV + 1);

  localparam logic [CW-1:0] SET_LD  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] MEAS_LD = CW'(MEAS_CYC - 1);
  localparam logic [AW:0]   HYST_X  = (AW+1)'(HYST);
  localparam logic [AW:0]   SAT_X   = (AW+1)'(SAT_LEVEL);
  localparam logic [RW-1:0] REV_TOP = RW'(OPT_REV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DECIDE,
    STEP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [AW-1:0] amp;
  logic [AW-1:0] peak;
  logic [AW-1:0] prev;
  logic          prev_valid;
  logic [RW-1:0] rev_cnt;
  logic [AW:0]   p_x;
  logic [AW:0]   prev_x;
  logic          fall;
  logic          sat;
  logic          rev_inc;
  logic          opt_hit;

  // Offset-binary fold: below midscale the magnitude is the bitwise inverse.
  assign amp = adc_in[ADC_W-1] ? adc_in[AW-1:0]
                               : ~adc_in[AW-1:0];

  assign p_x     = {1'b0, peak};
  assign prev_x  = {1'b0, prev};
  assign fall    = (p_x + HYST_X) < prev_x;
  assign sat     = p_x >= SAT_X;
  assign rev_inc = prev_valid && fall;
  assign opt_hit = rev_inc && (rev_cnt == REV_TOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_req  = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: ;
      SETTLE: begin
        if (cnt == '0) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (cnt == '0) state_nxt = DECIDE;
      end
      DECIDE: begin
        if (sat || opt_hit) state_nxt = IDLE;
        else state_nxt = STEP;
      end
      STEP: begin
        step_req = 1'b1;
        if (step_ack) state_nxt = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = SETTLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      peak       <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      rev_cnt    <= '0;
      step_up    <= 1'b1;
      freq_opt   <= 1'b0;
      sat_flag   <= 1'b0;
      best_freq  <= '0;
      best_amp   <= '0;
    end else if (start) begin
      cnt        <= SET_LD;
      peak       <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      rev_cnt    <= '0;
      step_up    <= 1'b1;
      freq_opt   <= 1'b0;
      sat_flag   <= 1'b0;
      best_freq  <= '0;
      best_amp   <= '0;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == '0) begin
            cnt  <= MEAS_LD;
            peak <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MEASURE: begin
          if (adc_valid && (amp > peak)) peak <= amp;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DECIDE: begin
          if (peak > best_amp) begin
            best_amp  <= peak;
            best_freq <= freq;
          end
          if (sat) begin
            sat_flag <= 1'b1;
          end else begin
            prev       <= peak;
            prev_valid <= 1'b1;
            if (rev_inc) begin
              step_up <= ~step_up;
              rev_cnt <= rev_cnt + 1'b1;
            end
            if (opt_hit) freq_opt <= 1'b1;
          end
        end
        STEP: begin
          if (step_ack) cnt <= SET_LD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_tracker.sv
// Scoreboard bench for freq_tracker: a per-sweep peak model predicts
// step directions and end-of-sweep results; a monitor checks them.
module tb_freq_tracker;

  localparam int ADC_W  = 12;
  localparam int FREQ_W = 20;
  localparam int SETTLE = 8;
  localparam int MEAS   = 16;
  localparam int HYST   = 4;
  localparam int OPT    = 2;
  localparam int SAT    = 1739;
  localparam int MID    = 2048;
  localparam int AMAX   = 2047;
  localparam int DF     = 37;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADC_W-1:0]  adc_in;
  logic              adc_valid;
  logic [FREQ_W-1:0] freq;
  logic              step_ack;
  logic              step_req;
  logic              step_up;
  logic              busy;
  logic              freq_opt;
  logic              sat_flag;
  logic [FREQ_W-1:0] best_freq;
  logic [ADC_W-2:0]  best_amp;

  freq_tracker #(
    .ADC_W(ADC_W), .FREQ_W(FREQ_W), .SETTLE_CYC(SETTLE),
    .MEAS_CYC(MEAS), .HYST(HYST), .OPT_REV(OPT), .SAT_LEVEL(SAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .adc_in(adc_in),
    .adc_valid(adc_valid), .freq(freq), .step_ack(step_ack),
    .step_req(step_req), .step_up(step_up), .busy(busy),
    .freq_opt(freq_opt), .sat_flag(sat_flag),
    .best_freq(best_freq), .best_amp(best_amp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_end;
    bit up;
    bit opt;
    bit sat;
    int amp;
    int bf;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t",
               name, act, req, $time);
    end
  endtask

  logic p_busy = 1'b0;
  logic p_req  = 1'b0;
  logic p_up   = 1'b1;
  logic p_ack  = 1'b0;

  // Monitor: handshakes and busy falling edges consume expected events.
  always @(negedge clk) begin
    ev_t e;
    if (step_req && p_req && !p_ack)
      check("step_up_stable", step_up, p_up);
    if (step_req && step_ack) begin
      if (exp_q.size() == 0 || exp_q[0].is_end) begin
        checks++;
        errors++;
        $display("FAIL step_unexpected: got step, want none at %0t",
                 $time);
      end else begin
        e = exp_q.pop_front();
        check("step_dir", step_up, e.up);
      end
    end
    if (p_busy && !busy) begin
      if (exp_q.size() == 0 || !exp_q[0].is_end) begin
        checks++;
        errors++;
        $display("FAIL end_unexpected: got idle, want %0d steps at %0t",
                 exp_q.size(), $time);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        check("end_opt", freq_opt, e.opt);
        check("end_sat", sat_flag, e.sat);
        check("end_best_amp", best_amp, e.amp);
        check("end_best_freq", best_freq, e.bf);
        check("end_no_req", step_req, 0);
      end
    end
    p_busy = busy;
    p_req  = step_req;
    p_up   = step_up;
    p_ack  = step_ack;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_adc(input int a, input bit hi);
    adc_in = hi ? ADC_W'(MID + a) : ADC_W'(MID - 1 - a);
  endtask

  // Samples that must be ignored: larger than the window peak.
  task automatic junk(input int p, input bit quiet);
    if (quiet) begin
      put_adc(p, p < SAT);
      adc_valid = 1'b1;
      step_ack  = 1'b1;
    end else begin
      put_adc(p >= AMAX ? AMAX : int'($urandom_range(p + 1, AMAX)),
              1'($urandom));
      adc_valid = 1'b1;
      step_ack  = 1'($urandom);
    end
  endtask

  task automatic meas(input int p, input bit hit, input bit quiet);
    if (quiet || hit) begin
      put_adc(p, quiet ? (p < SAT) : 1'($urandom));
      adc_valid = 1'b1;
    end else begin
      adc_valid = 1'($urandom);
      put_adc(adc_valid ? int'($urandom_range(0, p))
                        : int'($urandom_range(0, AMAX)),
              1'($urandom));
    end
    step_ack = quiet ? 1'b1 : 1'($urandom);
  endtask

  task automatic rand_peaks(output int pk[$]);
    int n;
    int p;
    int last;
    pk.delete();
    n    = int'($urandom_range(3, 9));
    last = int'($urandom_range(16, 1700));
    for (int i = 0; i < n; i++) begin
      if (i > 0 && ($urandom % 3) == 0)
        p = last + int'($urandom_range(0, 8)) - 4;
      else
        p = int'($urandom_range(16, 1700));
      if (p < 0) p = 0;
      if (p > SAT - 1) p = SAT - 1;
      pk.push_back(p);
      last = p;
    end
    pk.push_back(int'($urandom_range(SAT, AMAX)));
  endtask

  // One sweep: predict the outcome from the window peaks, then drive it.
  task automatic run_sweep(input int pk[$], input int abort_win,
                           input bit quiet);
    int prev = 0;
    int rev  = 0;
    int best = 0;
    int bf   = 0;
    int f;
    int nwin;
    int d;
    int hit;
    bit pv   = 1'b0;
    bit up   = 1'b1;
    bit done = 1'b0;
    int bests[$];
    bit dirs[$];
    f    = int'(freq);
    nwin = (abort_win >= 0) ? abort_win + 1 : pk.size();
    for (int w = 0; w < pk.size(); w++) begin
      if (w == abort_win) break;
      if (pk[w] > best) begin
        best = pk[w];
        bf   = f;
      end
      bests.push_back(best);
      if (pk[w] >= SAT) begin
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, best, bf});
        done = 1'b1;
        nwin = w + 1;
        break;
      end
      if (pv && (pk[w] + HYST < prev)) begin
        up = !up;
        rev++;
      end
      pv   = 1'b1;
      prev = pk[w];
      if (rev == OPT) begin
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, best, bf});
        done = 1'b1;
        nwin = w + 1;
        break;
      end
      exp_q.push_back('{1'b0, up, 1'b0, 1'b0, 0, 0});
      dirs.push_back(up);
      f = up ? f + DF : f - DF;
    end

    junk(pk[0], quiet);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("best_amp_cleared", best_amp, 0);
    check("flags_cleared", {freq_opt, sat_flag}, 0);
    check("step_up_start", step_up, 1);
    for (int w = 0; w < nwin; w++) begin
      hit = int'($urandom_range(0, MEAS - 1));
      repeat (SETTLE) begin
        junk(pk[w], quiet);
        cyc();
      end
      for (int c = 0; c < MEAS; c++) begin
        if (w == abort_win && c == 5) return;
        meas(pk[w], c == hit, quiet);
        cyc();
      end
      junk(pk[w], quiet);
      check("no_req_decide", step_req, 0);
      cyc();
      check("best_amp", best_amp, bests[w]);
      if (done && w == nwin - 1) break;
      check("req_in_step", step_req, 1);
      if (quiet) d = 0;
      else if (($urandom % 4) == 0) d = 10;
      else d = int'($urandom_range(0, 3));
      repeat (d) begin
        junk(pk[w], quiet);
        step_ack = 1'b0;
        cyc();
      end
      step_ack = 1'b1;
      cyc();
      freq = dirs[w] ? freq + FREQ_W'(DF) : freq - FREQ_W'(DF);
    end
    step_ack = 1'b1;
    repeat (4) cyc();
    step_ack = 1'b0;
    check("idle_after_sweep", busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_step_req"}, step_req, 0);
    check({tag, "_step_up"}, step_up, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_flags"}, {freq_opt, sat_flag}, 0);
    check({tag, "_best"}, {best_amp, best_freq}, 0);
  endtask

  initial begin
    int pk[$];
    rst       = 1'b1;
    start     = 1'b0;
    adc_valid = 1'b0;
    step_ack  = 1'b0;
    adc_in    = '0;
    freq      = FREQ_W'(100000);
    repeat (3) cyc();
    check_reset_outs("reset");
    rst = 1'b0;
    cyc();

    pk = '{256, 256, 256, 1791};
    run_sweep(pk, -1, 1'b1);
    pk = '{256, 384, 288, 416, 272};
    run_sweep(pk, -1, 1'b1);
    pk = '{256, 259, 256, 240, 224};
    run_sweep(pk, -1, 1'b1);
    pk = '{1791};
    run_sweep(pk, -1, 1'b1);
    pk = '{1738, 1739};
    run_sweep(pk, -1, 1'b0);
    repeat (8) begin
      rand_peaks(pk);
      run_sweep(pk, -1, 1'b0);
    end

    rand_peaks(pk);
    run_sweep(pk, 1, 1'b0);
    check("abort_queue", exp_q.size(), 0);
    rand_peaks(pk);
    run_sweep(pk, -1, 1'b0);

    rand_peaks(pk);
    run_sweep(pk, 1, 1'b0);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_outs("mid_rst");
    cyc();
    rand_peaks(pk);
    run_sweep(pk, -1, 1'b0);

    rand_peaks(pk);
    run_sweep(pk, 1, 1'b0);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
    rst   = 1'b1;
    start = 1'b1;
    cyc();
    rst   = 1'b0;
    start = 1'b0;
    check_reset_outs("rst_start");
    cyc();
    check("rst_start_idle", busy, 0);
    rand_peaks(pk);
    run_sweep(pk, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
